regfile_dump_reader: RTL and testbench
======================================

// Module: regfile_dump_reader
// PURPOSE
//  Debug read-out engine for the multi-cycle MIPS register file. On a start pulse it walks
//  register addresses in order via a spare combinational read port and streams each
//  {address, data} pair over a valid/ready interface to the debug/UART path.
//  Passive reader only: never drives we3/A3/WD3. The CPU keeps running and writing during a dump.
// PARAMETERS
//  ADDR_WIDTH  5   register address width; 2**ADDR_WIDTH registers walked
//  DATA_WIDTH  32  register data width
//  SKIP_ZERO   0   1 = start walk at address 1 (omit $zero), 0 = start at address 0
// PORTS
//  clk        in   1           single clock; all state updates on posedge
//  rst_n      in   1           asynchronous, active-low reset
//  start      in   1           one-cycle request to begin a dump; ignored while busy
//  abort      in   1           cancel the dump in progress; wins over start in the same cycle
//  rd_addr    out  ADDR_WIDTH  read address to the register file spare port (A1/A2 style)
//  rd_data    in   DATA_WIDTH  combinational read data for rd_addr
//  out_valid  out  1           output word valid
//  out_ready  in   1           downstream accepts the word when out_valid && out_ready
//  out_addr   out  ADDR_WIDTH  register address of out_data
//  out_data   out  DATA_WIDTH  captured register value
//  out_last   out  1           qualifies the final word of the dump (address 2**ADDR_WIDTH-1)
//  busy       out  1           high from the cycle after start is accepted until done/abort
//  done       out  1           one-cycle pulse after the last word handshakes
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE, ptr=FIRST, out_valid=0, out_addr=0, out_data=0,
//   out_last=0, busy=0, done=0. FIRST = SKIP_ZERO ? 1 : 0. rd_addr = ptr (comb.) at all times.
//  FSM: IDLE -> RUN (start && !abort sampled); RUN -> DRAIN (last address captured);
//   DRAIN -> IDLE (last word handshakes; done=1 for that next cycle). abort: any state -> IDLE.
//  IDLE: ptr=FIRST; out_valid=0; busy=0.
//  Capture rule (RUN only): load = !out_valid || out_ready. On load: out_data<=rd_data,
//   out_addr<=ptr, out_valid<=1, out_last<=(ptr==2**ADDR_WIDTH-1), ptr<=ptr+1 unless last.
//   Capturing the last address moves to DRAIN; no further loads.
//  Throughput one word/cycle with out_ready held high. Latency: start sampled at edge E0 ->
//   busy high after E0; first word captured at E1 -> out_valid high after E1.
//  Backpressure: out_valid && !out_ready holds out_addr/out_data/out_last and ptr stable.
//  out_valid never drops without a handshake except on abort or reset.
//  Snapshot semantics: each word is the register value at its capture edge; a CPU write to the
//   same register at that edge is NOT seen (old value). No whole-file atomicity.
//  ptr never wraps: last address is terminal; ptr width ADDR_WIDTH, no overflow possible.
//  DRAIN: holds last word until handshake; the handshake edge clears out_valid/out_last/busy
//   and sets done=1 for exactly one cycle.
//  start while busy (RUN/DRAIN): ignored, no restart. start in the done cycle: accepted.
//  abort: next edge clears out_valid, out_last, busy; done stays 0; ptr<=FIRST. abort in IDLE: no-op.
//  Reset mid-dump: immediate return to reset values; no done, no partial word kept.
// STRUCTURE
//  Shared package mips_pkg: REG_ADDR_W=5, REG_DATA_W=32, REG_COUNT=32 constants; dump FSM state
//   encoding (IDLE=2'd0, RUN=2'd1, DRAIN=2'd2) as named constants for the debug block decoder.
//  No sub-module is natural: one FSM, one pointer, one output register; keep flat.
//  Bench pairs it with the register file model, preloaded with registers[i]=32'hA000_0000+i.
// TESTING
//  1 Full dump, out_ready=1, SKIP_ZERO=0: start -> 32 words on consecutive cycles, addr 0..31,
//    data 32'hA000_0000..32'hA000_001F, out_last only on addr 31, done 1 cycle after, busy low.
//  2 Backpressure: drop out_ready 3 cycles while addr 5 is valid -> addr 5/32'hA000_0005 held
//    stable, rd_addr held at 6, no word lost or duplicated, 32 handshakes total.
//  3 SKIP_ZERO=1: start -> 31 words, first addr 1, last addr 31 with out_last, then done.
//  4 Write collision: CPU writes reg 10 <= 32'hDEAD_BEEF on the edge capturing addr 10 -> dump
//    shows 32'hA000_000A; repeat dump shows 32'hDEAD_BEEF.
//  5 Abort after addr 12 handshake -> out_valid/busy low next cycle, done never pulses; new start
//    restarts at addr 0. start+abort same cycle in IDLE -> stays IDLE.
//  6 rst_n low asynchronously mid-dump (addr 20, out_ready=0) -> outputs zero without clock edge;
//    after release, start yields a clean full dump from addr 0.

Source files
------------

// File: rtl/regfile_dump_reader_pkg.sv
// Shared register-file constants and dump FSM encoding, visible to the debug block decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regfile_dump_reader_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int REG_COUNT  = 32;

    // Encoding is fixed so the debug decoder can interpret a raw state readback.
    typedef enum logic [1:0] {
        DUMP_IDLE  = 2'd0,
        DUMP_RUN   = 2'd1,
        DUMP_DRAIN = 2'd2
    } dump_state_e;

    // First address walked: $zero can be omitted since it always reads 0.
    function automatic int first_addr(input int skip_zero);
        return (skip_zero != 0) ? 1 : 0;
    endfunction

endpackage

// File: rtl/regfile_dump_reader_if.sv
// Valid/ready stream carrying {address, data, last} words from the dump reader.
// Latency: n/a (wires only).
// Backpressure: producer holds all fields while out_valid && !out_ready.
interface regfile_dump_reader_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic                  out_valid;
    logic                  out_ready;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;

    modport master (
        output out_valid,
        input  out_ready,
        output out_addr,
        output out_data,
        output out_last
    );

    modport slave (
        input  out_valid,
        output out_ready,
        input  out_addr,
        input  out_data,
        input  out_last
    );
endinterface

// File: rtl/regfile_dump_reader.sv
// Walks the register file through a spare read port and streams {addr, data} words.
// Latency: start at edge E0 -> busy after E0, first word valid after E1; 1 word/cycle.
// Backpressure: out_valid && !out_ready freezes the output word and the read pointer.
module regfile_dump_reader
    import regfile_dump_reader_pkg::*;
#(
    parameter int ADDR_WIDTH = REG_ADDR_W,
    parameter int DATA_WIDTH = REG_DATA_W,
    parameter int SKIP_ZERO  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    regfile_dump_reader_if.master out,
    output logic                  busy,
    output logic                  done
);

    localparam logic [ADDR_WIDTH-1:0] FIRST = ADDR_WIDTH'(first_addr(SKIP_ZERO));
    localparam logic [ADDR_WIDTH-1:0] LAST  = {ADDR_WIDTH{1'b1}};

    dump_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q,   ptr_d;
    logic                  vld_q,   vld_d;
    logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic [DATA_WIDTH-1:0] data_q,  data_d;
    logic                  last_q,  last_d;
    logic                  done_q,  done_d;

    // Register the FSM, pointer and the single-entry output word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DUMP_IDLE;
            ptr_q   <= FIRST;
            vld_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            vld_q   <= vld_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    // Next-state: capture a word whenever the output slot is free or being drained;
    // abort overrides everything and returns to IDLE without a done pulse.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        vld_d   = vld_q;
        addr_d  = addr_q;
        data_d  = data_q;
        last_d  = last_q;
        done_d  = 1'b0;

        if (abort) begin
            state_d = DUMP_IDLE;
            ptr_d   = FIRST;
            vld_d   = 1'b0;
            last_d  = 1'b0;
        end else begin
            case (state_q)
                DUMP_IDLE: begin
                    ptr_d  = FIRST;
                    vld_d  = 1'b0;
                    last_d = 1'b0;
                    if (start) begin
                        state_d = DUMP_RUN;
                    end
                end
                DUMP_RUN: begin
                    if (!vld_q || out.out_ready) begin
                        // rd_data is sampled at this edge, so a concurrent CPU write
                        // to the same register is not observed in this word.
                        data_d = rd_data;
                        addr_d = ptr_q;
                        vld_d  = 1'b1;
                        last_d = (ptr_q == LAST);
                        if (ptr_q == LAST) begin
                            state_d = DUMP_DRAIN;
                        end else begin
                            ptr_d = ptr_q + 1'b1;
                        end
                    end
                end
                DUMP_DRAIN: begin
                    if (out.out_ready) begin
                        state_d = DUMP_IDLE;
                        ptr_d   = FIRST;
                        vld_d   = 1'b0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = DUMP_IDLE;
                    ptr_d   = FIRST;
                    vld_d   = 1'b0;
                    last_d  = 1'b0;
                end
            endcase
        end
    end

    assign rd_addr       = ptr_q;
    assign busy          = (state_q != DUMP_IDLE);
    assign done          = done_q;
    assign out.out_valid = vld_q;
    assign out.out_addr  = addr_q;
    assign out.out_data  = data_q;
    assign out.out_last  = last_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Drives two dump readers (SKIP_ZERO 0 and 1) against a shared register-file model.
// Latency: n/a.
// Backpressure: bench controls out_ready per reader (held, scripted stall, random).
module tb_regfile_dump_reader;
    import regfile_dump_reader_pkg::*;

    localparam int AW   = REG_ADDR_W;
    localparam int DW   = REG_DATA_W;
    localparam int NREG = REG_COUNT;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Register file model: preloaded while in reset, one write port.
    logic [DW-1:0] regs [NREG];
    logic          we = 1'b0;
    logic [AW-1:0] wa = '0;
    logic [DW-1:0] wd = '0;
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= 32'hA000_0000 + i;
        end else if (we) begin
            regs[wa] <= wd;
        end
    end

    // Reference contents the dump is expected to report.
    logic [DW-1:0] exp_regs [NREG];

    logic drv_start [2];
    logic drv_abort [2];
    logic drv_ready [2];

    logic [AW-1:0] rd_addr0, rd_addr1;
    logic          busy0, busy1, done0, done1;

    regfile_dump_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
    regfile_dump_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();

    assign bus0.out_ready = drv_ready[0];
    assign bus1.out_ready = drv_ready[1];

    regfile_dump_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SKIP_ZERO(0)) dut0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (drv_start[0]),
        .abort   (drv_abort[0]),
        .rd_addr (rd_addr0),
        .rd_data (regs[rd_addr0]),
        .out     (bus0),
        .busy    (busy0),
        .done    (done0)
    );

    regfile_dump_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SKIP_ZERO(1)) dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (drv_start[1]),
        .abort   (drv_abort[1]),
        .rd_addr (rd_addr1),
        .rd_data (regs[rd_addr1]),
        .out     (bus1),
        .busy    (busy1),
        .done    (done1)
    );

    // Indexable views of both readers.
    logic          s_vld [2], s_last [2], s_busy [2], s_done [2];
    logic [AW-1:0] s_addr [2], s_rda [2];
    logic [DW-1:0] s_data [2];
    always_comb begin
        s_vld[0]  = bus0.out_valid; s_vld[1]  = bus1.out_valid;
        s_last[0] = bus0.out_last;  s_last[1] = bus1.out_last;
        s_addr[0] = bus0.out_addr;  s_addr[1] = bus1.out_addr;
        s_data[0] = bus0.out_data;  s_data[1] = bus1.out_data;
        s_busy[0] = busy0;          s_busy[1] = busy1;
        s_done[0] = done0;          s_done[1] = done1;
        s_rda[0]  = rd_addr0;       s_rda[1]  = rd_addr1;
    end

    // Observations collected by run_dump.
    logic [AW-1:0] q_addr [$];
    logic [DW-1:0] q_data [$];
    logic          q_last [$];
    int            q_cyc  [$];
    int   done_cnt, done_cyc, stab_err, rd_err, stalls;
    logic busy_e0, vld_e0, busy_at_done;

    // mode 0: ready held high; 1: three-cycle stall on addr 5; 2: random ready.
    // wr_addr >= 0 schedules a CPU write on the edge that captures that address.
    task automatic run_dump(input int d, input int mode, input int wr_addr, input logic [DW-1:0] wr_val);
        logic          r;
        logic          prev_stall;
        logic [AW-1:0] p_addr;
        logic [DW-1:0] p_data;
        logic          p_last;
        logic [AW-1:0] wa_l;
        bit            wrote;
        q_addr.delete(); q_data.delete(); q_last.delete(); q_cyc.delete();
        done_cnt = 0; done_cyc = -1; stab_err = 0; rd_err = 0; stalls = 0;
        busy_at_done = 1'b1; prev_stall = 1'b0; wrote = 1'b0;
        p_addr = '0; p_data = '0; p_last = 1'b0;
        wa_l = AW'(wr_addr);
        @(negedge clk);
        drv_ready[d] = 1'b1;
        drv_start[d] = 1'b1;
        @(negedge clk);
        drv_start[d] = 1'b0;
        busy_e0 = s_busy[d];
        vld_e0  = s_vld[d];
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (prev_stall && (!s_vld[d] || s_addr[d] !== p_addr ||
                               s_data[d] !== p_data || s_last[d] !== p_last)) stab_err++;
            r = 1'b1;
            if (mode == 1 && s_vld[d] && s_addr[d] == AW'(5) && stalls < 3) begin
                r = 1'b0;
                stalls++;
                if (s_rda[d] !== AW'(6)) rd_err++;
            end else if (mode == 2) begin
                r = ($urandom_range(0, 3) != 0);
            end
            drv_ready[d] = r;
            we = 1'b0;
            if (wr_addr >= 0 && !wrote && s_busy[d] && s_rda[d] == wa_l && (!s_vld[d] || r)) begin
                we = 1'b1; wa = wa_l; wd = wr_val; wrote = 1'b1;
            end
            if (s_vld[d] && r) begin
                q_addr.push_back(s_addr[d]);
                q_data.push_back(s_data[d]);
                q_last.push_back(s_last[d]);
                q_cyc.push_back(cyc);
            end
            prev_stall = s_vld[d] && !r;
            p_addr = s_addr[d]; p_data = s_data[d]; p_last = s_last[d];
            if (s_done[d]) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    busy_at_done = s_busy[d];
                end
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
            @(negedge clk);
        end
        we = 1'b0;
        drv_ready[d] = 1'b1;
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if (bus0.out_valid !== 1'b0 || bus0.out_addr !== '0 || bus0.out_data !== '0 ||
            bus0.out_last !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0 || rd_addr0 !== AW'(0))
            begin n_fail++; $display("FAIL reset_dut0: vld=%b addr=%0d data=%h last=%b busy=%b done=%b rd_addr=%0d, want all 0",
                bus0.out_valid, bus0.out_addr, bus0.out_data, bus0.out_last, busy0, done0, rd_addr0); end
        n_checks++;
        if (bus1.out_valid !== 1'b0 || bus1.out_addr !== '0 || busy1 !== 1'b0 || done1 !== 1'b0 || rd_addr1 !== AW'(1))
            begin n_fail++; $display("FAIL reset_dut1: vld=%b addr=%0d busy=%b done=%b rd_addr=%0d, want 0 0 0 0 1",
                bus1.out_valid, bus1.out_addr, busy1, done1, rd_addr1); end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_full_dump();
        run_dump(0, 0, -1, '0);
        n_checks++;
        if (busy_e0 !== 1'b1 || vld_e0 !== 1'b0)
            begin n_fail++; $display("FAIL full_start_latency: busy=%b vld=%b after E0, want 1 0", busy_e0, vld_e0); end
        n_checks++;
        if (q_addr.size() != 32)
            begin n_fail++; $display("FAIL full_count: got %0d words, want 32", q_addr.size()); end
        for (int i = 0; i < q_addr.size(); i++) begin
            n_checks++;
            if (q_addr[i] !== AW'(i) || q_data[i] !== exp_regs[i] || q_last[i] !== (i == 31))
                begin n_fail++; $display("FAIL full_word[%0d]: got addr=%0d data=%h last=%b, want addr=%0d data=%h last=%b",
                    i, q_addr[i], q_data[i], q_last[i], i, exp_regs[i], (i == 31)); end
        end
        n_checks++;
        if (q_cyc.size() != 32 || q_cyc[0] != 1 || q_cyc[q_cyc.size()-1] != 32)
            begin n_fail++; $display("FAIL full_throughput: first/last handshake cycle %0d/%0d, want 1/32",
                q_cyc.size() ? q_cyc[0] : -1, q_cyc.size() ? q_cyc[q_cyc.size()-1] : -1); end
        n_checks++;
        if (done_cnt != 1 || q_cyc.size() == 0 || done_cyc != q_cyc[q_cyc.size()-1] + 1 || busy_at_done !== 1'b0)
            begin n_fail++; $display("FAIL full_done: pulses=%0d at cycle %0d busy=%b, want 1 pulse right after last word, busy 0",
                done_cnt, done_cyc, busy_at_done); end
    endtask

    task automatic test_backpressure();
        run_dump(0, 1, -1, '0);
        n_checks++;
        if (stalls != 3 || stab_err != 0 || rd_err != 0)
            begin n_fail++; $display("FAIL bp_hold: stalls=%0d unstable=%0d rd_addr_errs=%0d, want 3 0 0", stalls, stab_err, rd_err); end
        n_checks++;
        if (q_addr.size() != 32)
            begin n_fail++; $display("FAIL bp_count: got %0d handshakes, want 32", q_addr.size()); end
        for (int i = 0; i < q_addr.size(); i++) begin
            n_checks++;
            if (q_addr[i] !== AW'(i) || q_data[i] !== exp_regs[i])
                begin n_fail++; $display("FAIL bp_word[%0d]: got addr=%0d data=%h, want addr=%0d data=%h",
                    i, q_addr[i], q_data[i], i, exp_regs[i]); end
        end
        n_checks++;
        if (done_cnt != 1)
            begin n_fail++; $display("FAIL bp_done: pulses=%0d, want 1", done_cnt); end
    endtask

    // mode 0 for a clean pass, mode 2 for random backpressure.
    task automatic test_skip_zero(input int mode);
        run_dump(1, mode, -1, '0);
        n_checks++;
        if (q_addr.size() != 31)
            begin n_fail++; $display("FAIL skip_count(mode %0d): got %0d words, want 31", mode, q_addr.size()); end
        for (int i = 0; i < q_addr.size(); i++) begin
            n_checks++;
            if (q_addr[i] !== AW'(i + 1) || q_data[i] !== exp_regs[i + 1] || q_last[i] !== (i == 30))
                begin n_fail++; $display("FAIL skip_word[%0d]: got addr=%0d data=%h last=%b, want addr=%0d data=%h last=%b",
                    i, q_addr[i], q_data[i], q_last[i], i + 1, exp_regs[i + 1], (i == 30)); end
        end
        n_checks++;
        if (done_cnt != 1 || stab_err != 0 || busy_at_done !== 1'b0)
            begin n_fail++; $display("FAIL skip_done(mode %0d): pulses=%0d unstable=%0d busy=%b, want 1 0 0",
                mode, done_cnt, stab_err, busy_at_done); end
    endtask

    task automatic test_write_collision();
        run_dump(0, 0, 10, 32'hDEAD_BEEF);
        n_checks++;
        if (q_data.size() != 32 || q_data[10] !== exp_regs[10])
            begin n_fail++; $display("FAIL collision_old: got %h for reg 10, want %h", q_data.size() > 10 ? q_data[10] : '0, exp_regs[10]); end
        exp_regs[10] = 32'hDEAD_BEEF;
        run_dump(0, 0, -1, '0);
        n_checks++;
        if (q_data.size() != 32 || q_data[10] !== exp_regs[10])
            begin n_fail++; $display("FAIL collision_new: got %h for reg 10, want %h", q_data.size() > 10 ? q_data[10] : '0, exp_regs[10]); end
        // Put the preload value back through the write port.
        @(negedge clk); we = 1'b1; wa = AW'(10); wd = 32'hA000_000A;
        @(negedge clk); we = 1'b0;
        exp_regs[10] = 32'hA000_000A;
    endtask

    task automatic test_abort();
        int found = 0;
        int dn = 0;
        @(negedge clk); drv_ready[0] = 1'b1; drv_start[0] = 1'b1;
        @(negedge clk); drv_start[0] = 1'b0;
        for (int c = 0; c < 100 && found == 0; c++) begin
            if (s_vld[0] && s_addr[0] == AW'(12)) found = 1;
            @(negedge clk);
        end
        n_checks++;
        if (found == 0) begin n_fail++; $display("FAIL abort_reach12: addr 12 never valid, want it within 100 cycles"); end
        drv_abort[0] = 1'b1;
        @(negedge clk); drv_abort[0] = 1'b0;
        n_checks++;
        if (bus0.out_valid !== 1'b0 || busy0 !== 1'b0 || bus0.out_last !== 1'b0 || rd_addr0 !== AW'(0))
            begin n_fail++; $display("FAIL abort_clear: vld=%b busy=%b last=%b rd_addr=%0d, want 0 0 0 0",
                bus0.out_valid, busy0, bus0.out_last, rd_addr0); end
        if (done0) dn++;
        for (int c = 0; c < 6; c++) begin @(negedge clk); if (done0) dn++; end
        n_checks++;
        if (dn != 0) begin n_fail++; $display("FAIL abort_nodone: done pulsed %0d times, want 0", dn); end
        run_dump(0, 0, -1, '0);
        n_checks++;
        if (q_addr.size() != 32 || q_addr[0] !== AW'(0) || q_last[q_addr.size()-1] !== 1'b1)
            begin n_fail++; $display("FAIL abort_restart: %0d words first addr %0d, want 32 words from 0", q_addr.size(),
                q_addr.size() ? q_addr[0] : '1); end
        @(negedge clk); drv_start[0] = 1'b1; drv_abort[0] = 1'b1;
        @(negedge clk); drv_start[0] = 1'b0; drv_abort[0] = 1'b0;
        n_checks++;
        if (busy0 !== 1'b0 || bus0.out_valid !== 1'b0)
            begin n_fail++; $display("FAIL abort_idle_start: busy=%b vld=%b, want 0 0", busy0, bus0.out_valid); end
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy0 !== 1'b0 || done0 !== 1'b0 || bus0.out_valid !== 1'b0)
            begin n_fail++; $display("FAIL abort_idle_stays: busy=%b done=%b vld=%b, want 0 0 0", busy0, done0, bus0.out_valid); end
    endtask

    task automatic test_reset_mid_dump();
        int found = 0;
        @(negedge clk); drv_ready[0] = 1'b1; drv_start[0] = 1'b1;
        @(negedge clk); drv_start[0] = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (s_vld[0] && s_addr[0] == AW'(20)) begin
                drv_ready[0] = 1'b0;
                found = 1;
                break;
            end
            @(negedge clk);
        end
        n_checks++;
        if (found == 0) begin n_fail++; $display("FAIL rst_reach20: addr 20 never valid, want it within 100 cycles"); end
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus0.out_valid !== 1'b0 || bus0.out_addr !== '0 || bus0.out_data !== '0 || bus0.out_last !== 1'b0 ||
            busy0 !== 1'b0 || done0 !== 1'b0 || rd_addr0 !== AW'(0))
            begin n_fail++; $display("FAIL rst_async: vld=%b addr=%0d data=%h last=%b busy=%b done=%b rd_addr=%0d, want all 0",
                bus0.out_valid, bus0.out_addr, bus0.out_data, bus0.out_last, busy0, done0, rd_addr0); end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        drv_ready[0] = 1'b1;
        run_dump(0, 0, -1, '0);
        n_checks++;
        if (q_addr.size() != 32 || done_cnt != 1)
            begin n_fail++; $display("FAIL rst_redump_count: %0d words %0d done, want 32 and 1", q_addr.size(), done_cnt); end
        for (int i = 0; i < q_addr.size(); i++) begin
            n_checks++;
            if (q_addr[i] !== AW'(i) || q_data[i] !== exp_regs[i])
                begin n_fail++; $display("FAIL rst_redump_word[%0d]: got addr=%0d data=%h, want addr=%0d data=%h",
                    i, q_addr[i], q_data[i], i, exp_regs[i]); end
        end
    endtask

    initial begin
        for (int i = 0; i < NREG; i++) exp_regs[i] = 32'hA000_0000 + i;
        for (int d = 0; d < 2; d++) begin
            drv_start[d] = 1'b0;
            drv_abort[d] = 1'b0;
            drv_ready[d] = 1'b1;
        end
        test_reset();
        test_full_dump();
        test_backpressure();
        test_skip_zero(0);
        test_skip_zero(2);
        test_write_collision();
        test_abort();
        test_reset_mid_dump();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
